// File: rtl/aes_pkg.sv
// aes_pkg: AES-128 constants, S-boxes and round helper functions
package aes_pkg;
  localparam int NR = 10;
  localparam int NK = 4;
  localparam logic [7:0] RCON [0:10] = '{8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'h00: r = 8'h63; 8'h01: r = 8'h7c; 8'h02: r = 8'h77; 8'h03: r = 8'h7b; 8'h04: r = 8'hf2; 8'h05: r = 8'h6b; 8'h06: r = 8'h6f; 8'h07: r = 8'hc5; 8'h08: r = 8'h30; 8'h09: r = 8'h01; 8'h0a: r = 8'h67; 8'h0b: r = 8'h2b; 8'h0c: r = 8'hfe; 8'h0d: r = 8'hd7; 8'h0e: r = 8'hab; 8'h0f: r = 8'h76;
      8'h10: r = 8'hca; 8'h11: r = 8'h82; 8'h12: r = 8'hc9; 8'h13: r = 8'h7d; 8'h14: r = 8'hfa; 8'h15: r = 8'h59; 8'h16: r = 8'h47; 8'h17: r = 8'hf0; 8'h18: r = 8'had; 8'h19: r = 8'hd4; 8'h1a: r = 8'ha2; 8'h1b: r = 8'haf; 8'h1c: r = 8'h9c; 8'h1d: r = 8'ha4; 8'h1e: r = 8'h72; 8'h1f: r = 8'hc0;
      8'h20: r = 8'hb7; 8'h21: r = 8'hfd; 8'h22: r = 8'h93; 8'h23: r = 8'h26; 8'h24: r = 8'h36; 8'h25: r = 8'h3f; 8'h26: r = 8'hf7; 8'h27: r = 8'hcc; 8'h28: r = 8'h34; 8'h29: r = 8'ha5; 8'h2a: r = 8'he5; 8'h2b: r = 8'hf1; 8'h2c: r = 8'h71; 8'h2d: r = 8'hd8; 8'h2e: r = 8'h31; 8'h2f: r = 8'h15;
      8'h30: r = 8'h04; 8'h31: r = 8'hc7; 8'h32: r = 8'h23; 8'h33: r = 8'hc3; 8'h34: r = 8'h18; 8'h35: r = 8'h96; 8'h36: r = 8'h05; 8'h37: r = 8'h9a; 8'h38: r = 8'h07; 8'h39: r = 8'h12; 8'h3a: r = 8'h80; 8'h3b: r = 8'he2; 8'h3c: r = 8'heb; 8'h3d: r = 8'h27; 8'h3e: r = 8'hb2; 8'h3f: r = 8'h75;
      8'h40: r = 8'h09; 8'h41: r = 8'h83; 8'h42: r = 8'h2c; 8'h43: r = 8'h1a; 8'h44: r = 8'h1b; 8'h45: r = 8'h6e; 8'h46: r = 8'h5a; 8'h47: r = 8'ha0; 8'h48: r = 8'h52; 8'h49: r = 8'h3b; 8'h4a: r = 8'hd6; 8'h4b: r = 8'hb3; 8'h4c: r = 8'h29; 8'h4d: r = 8'he3; 8'h4e: r = 8'h2f; 8'h4f: r = 8'h84;
      8'h50: r = 8'h53; 8'h51: r = 8'hd1; 8'h52: r = 8'h00; 8'h53: r = 8'hed; 8'h54: r = 8'h20; 8'h55: r = 8'hfc; 8'h56: r = 8'hb1; 8'h57: r = 8'h5b; 8'h58: r = 8'h6a; 8'h59: r = 8'hcb; 8'h5a: r = 8'hbe; 8'h5b: r = 8'h39; 8'h5c: r = 8'h4a; 8'h5d: r = 8'h4c; 8'h5e: r = 8'h58; 8'h5f: r = 8'hcf;
      8'h60: r = 8'hd0; 8'h61: r = 8'hef; 8'h62: r = 8'haa; 8'h63: r = 8'hfb; 8'h64: r = 8'h43; 8'h65: r = 8'h4d; 8'h66: r = 8'h33; 8'h67: r = 8'h85; 8'h68: r = 8'h45; 8'h69: r = 8'hf9; 8'h6a: r = 8'h02; 8'h6b: r = 8'h7f; 8'h6c: r = 8'h50; 8'h6d: r = 8'h3c; 8'h6e: r = 8'h9f; 8'h6f: r = 8'ha8;
      8'h70: r = 8'h51; 8'h71: r = 8'ha3; 8'h72: r = 8'h40; 8'h73: r = 8'h8f; 8'h74: r = 8'h92; 8'h75: r = 8'h9d; 8'h76: r = 8'h38; 8'h77: r = 8'hf5; 8'h78: r = 8'hbc; 8'h79: r = 8'hb6; 8'h7a: r = 8'hda; 8'h7b: r = 8'h21; 8'h7c: r = 8'h10; 8'h7d: r = 8'hff; 8'h7e: r = 8'hf3; 8'h7f: r = 8'hd2;
      8'h80: r = 8'hcd; 8'h81: r = 8'h0c; 8'h82: r = 8'h13; 8'h83: r = 8'hec; 8'h84: r = 8'h5f; 8'h85: r = 8'h97; 8'h86: r = 8'h44; 8'h87: r = 8'h17; 8'h88: r = 8'hc4; 8'h89: r = 8'ha7; 8'h8a: r = 8'h7e; 8'h8b: r = 8'h3d; 8'h8c: r = 8'h64; 8'h8d: r = 8'h5d; 8'h8e: r = 8'h19; 8'h8f: r = 8'h73;
      8'h90: r = 8'h60; 8'h91: r = 8'h81; 8'h92: r = 8'h4f; 8'h93: r = 8'hdc; 8'h94: r = 8'h22; 8'h95: r = 8'h2a; 8'h96: r = 8'h90; 8'h97: r = 8'h88; 8'h98: r = 8'h46; 8'h99: r = 8'hee; 8'h9a: r = 8'hb8; 8'h9b: r = 8'h14; 8'h9c: r = 8'hde; 8'h9d: r = 8'h5e; 8'h9e: r = 8'h0b; 8'h9f: r = 8'hdb;
      8'ha0: r = 8'he0; 8'ha1: r = 8'h32; 8'ha2: r = 8'h3a; 8'ha3: r = 8'h0a; 8'ha4: r = 8'h49; 8'ha5: r = 8'h06; 8'ha6: r = 8'h24; 8'ha7: r = 8'h5c; 8'ha8: r = 8'hc2; 8'ha9: r = 8'hd3; 8'haa: r = 8'hac; 8'hab: r = 8'h62; 8'hac: r = 8'h91; 8'had: r = 8'h95; 8'hae: r = 8'he4; 8'haf: r = 8'h79;
      8'hb0: r = 8'he7; 8'hb1: r = 8'hc8; 8'hb2: r = 8'h37; 8'hb3: r = 8'h6d; 8'hb4: r = 8'h8d; 8'hb5: r = 8'hd5; 8'hb6: r = 8'h4e; 8'hb7: r = 8'ha9; 8'hb8: r = 8'h6c; 8'hb9: r = 8'h56; 8'hba: r = 8'hf4; 8'hbb: r = 8'hea; 8'hbc: r = 8'h65; 8'hbd: r = 8'h7a; 8'hbe: r = 8'hae; 8'hbf: r = 8'h08;
      8'hc0: r = 8'hba; 8'hc1: r = 8'h78; 8'hc2: r = 8'h25; 8'hc3: r = 8'h2e; 8'hc4: r = 8'h1c; 8'hc5: r = 8'ha6; 8'hc6: r = 8'hb4; 8'hc7: r = 8'hc6; 8'hc8: r = 8'he8; 8'hc9: r = 8'hdd; 8'hca: r = 8'h74; 8'hcb: r = 8'h1f; 8'hcc: r = 8'h4b; 8'hcd: r = 8'hbd; 8'hce: r = 8'h8b; 8'hcf: r = 8'h8a;
      8'hd0: r = 8'h70; 8'hd1: r = 8'h3e; 8'hd2: r = 8'hb5; 8'hd3: r = 8'h66; 8'hd4: r = 8'h48; 8'hd5: r = 8'h03; 8'hd6: r = 8'hf6; 8'hd7: r = 8'h0e; 8'hd8: r = 8'h61; 8'hd9: r = 8'h35; 8'hda: r = 8'h57; 8'hdb: r = 8'hb9; 8'hdc: r = 8'h86; 8'hdd: r = 8'hc1; 8'hde: r = 8'h1d; 8'hdf: r = 8'h9e;
      8'he0: r = 8'he1; 8'he1: r = 8'hf8; 8'he2: r = 8'h98; 8'he3: r = 8'h11; 8'he4: r = 8'h69; 8'he5: r = 8'hd9; 8'he6: r = 8'h8e; 8'he7: r = 8'h94; 8'he8: r = 8'h9b; 8'he9: r = 8'h1e; 8'hea: r = 8'h87; 8'heb: r = 8'he9; 8'hec: r = 8'hce; 8'hed: r = 8'h55; 8'hee: r = 8'h28; 8'hef: r = 8'hdf;
      8'hf0: r = 8'h8c; 8'hf1: r = 8'ha1; 8'hf2: r = 8'h89; 8'hf3: r = 8'h0d; 8'hf4: r = 8'hbf; 8'hf5: r = 8'he6; 8'hf6: r = 8'h42; 8'hf7: r = 8'h68; 8'hf8: r = 8'h41; 8'hf9: r = 8'h99; 8'hfa: r = 8'h2d; 8'hfb: r = 8'h0f; 8'hfc: r = 8'hb0; 8'hfd: r = 8'h54; 8'hfe: r = 8'hbb; 8'hff: r = 8'h16;
    endcase
    return r;
  endfunction
  function automatic logic [7:0] inv_sbox(input logic [7:0] a);
    logic [7:0] r;
    case (a)
      8'h00: r = 8'h52; 8'h01: r = 8'h09; 8'h02: r = 8'h6a; 8'h03: r = 8'hd5; 8'h04: r = 8'h30; 8'h05: r = 8'h36; 8'h06: r = 8'ha5; 8'h07: r = 8'h38; 8'h08: r = 8'hbf; 8'h09: r = 8'h40; 8'h0a: r = 8'ha3; 8'h0b: r = 8'h9e; 8'h0c: r = 8'h81; 8'h0d: r = 8'hf3; 8'h0e: r = 8'hd7; 8'h0f: r = 8'hfb;
      8'h10: r = 8'h7c; 8'h11: r = 8'he3; 8'h12: r = 8'h39; 8'h13: r = 8'h82; 8'h14: r = 8'h9b; 8'h15: r = 8'h2f; 8'h16: r = 8'hff; 8'h17: r = 8'h87; 8'h18: r = 8'h34; 8'h19: r = 8'h8e; 8'h1a: r = 8'h43; 8'h1b: r = 8'h44; 8'h1c: r = 8'hc4; 8'h1d: r = 8'hde; 8'h1e: r = 8'he9; 8'h1f: r = 8'hcb;
      8'h20: r = 8'h54; 8'h21: r = 8'h7b; 8'h22: r = 8'h94; 8'h23: r = 8'h32; 8'h24: r = 8'ha6; 8'h25: r = 8'hc2; 8'h26: r = 8'h23; 8'h27: r = 8'h3d; 8'h28: r = 8'hee; 8'h29: r = 8'h4c; 8'h2a: r = 8'h95; 8'h2b: r = 8'h0b; 8'h2c: r = 8'h42; 8'h2d: r = 8'hfa; 8'h2e: r = 8'hc3; 8'h2f: r = 8'h4e;
      8'h30: r = 8'h08; 8'h31: r = 8'h2e; 8'h32: r = 8'ha1; 8'h33: r = 8'h66; 8'h34: r = 8'h28; 8'h35: r = 8'hd9; 8'h36: r = 8'h24; 8'h37: r = 8'hb2; 8'h38: r = 8'h76; 8'h39: r = 8'h5b; 8'h3a: r = 8'ha2; 8'h3b: r = 8'h49; 8'h3c: r = 8'h6d; 8'h3d: r = 8'h8b; 8'h3e: r = 8'hd1; 8'h3f: r = 8'h25;
      8'h40: r = 8'h72; 8'h41: r = 8'hf8; 8'h42: r = 8'hf6; 8'h43: r = 8'h64; 8'h44: r = 8'h86; 8'h45: r = 8'h68; 8'h46: r = 8'h98; 8'h47: r = 8'h16; 8'h48: r = 8'hd4; 8'h49: r = 8'ha4; 8'h4a: r = 8'h5c; 8'h4b: r = 8'hcc; 8'h4c: r = 8'h5d; 8'h4d: r = 8'h65; 8'h4e: r = 8'hb6; 8'h4f: r = 8'h92;
      8'h50: r = 8'h6c; 8'h51: r = 8'h70; 8'h52: r = 8'h48; 8'h53: r = 8'h50; 8'h54: r = 8'hfd; 8'h55: r = 8'hed; 8'h56: r = 8'hb9; 8'h57: r = 8'hda; 8'h58: r = 8'h5e; 8'h59: r = 8'h15; 8'h5a: r = 8'h46; 8'h5b: r = 8'h57; 8'h5c: r = 8'ha7; 8'h5d: r = 8'h8d; 8'h5e: r = 8'h9d; 8'h5f: r = 8'h84;
      8'h60: r = 8'h90; 8'h61: r = 8'hd8; 8'h62: r = 8'hab; 8'h63: r = 8'h00; 8'h64: r = 8'h8c; 8'h65: r = 8'hbc; 8'h66: r = 8'hd3; 8'h67: r = 8'h0a; 8'h68: r = 8'hf7; 8'h69: r = 8'he4; 8'h6a: r = 8'h58; 8'h6b: r = 8'h05; 8'h6c: r = 8'hb8; 8'h6d: r = 8'hb3; 8'h6e: r = 8'h45; 8'h6f: r = 8'h06;
      8'h70: r = 8'hd0; 8'h71: r = 8'h2c; 8'h72: r = 8'h1e; 8'h73: r = 8'h8f; 8'h74: r = 8'hca; 8'h75: r = 8'h3f; 8'h76: r = 8'h0f; 8'h77: r = 8'h02; 8'h78: r = 8'hc1; 8'h79: r = 8'haf; 8'h7a: r = 8'hbd; 8'h7b: r = 8'h03; 8'h7c: r = 8'h01; 8'h7d: r = 8'h13; 8'h7e: r = 8'h8a; 8'h7f: r = 8'h6b;
      8'h80: r = 8'h3a; 8'h81: r = 8'h91; 8'h82: r = 8'h11; 8'h83: r = 8'h41; 8'h84: r = 8'h4f; 8'h85: r = 8'h67; 8'h86: r = 8'hdc; 8'h87: r = 8'hea; 8'h88: r = 8'h97; 8'h89: r = 8'hf2; 8'h8a: r = 8'hcf; 8'h8b: r = 8'hce; 8'h8c: r = 8'hf0; 8'h8d: r = 8'hb4; 8'h8e: r = 8'he6; 8'h8f: r = 8'h73;
      8'h90: r = 8'h96; 8'h91: r = 8'hac; 8'h92: r = 8'h74; 8'h93: r = 8'h22; 8'h94: r = 8'he7; 8'h95: r = 8'had; 8'h96: r = 8'h35; 8'h97: r = 8'h85; 8'h98: r = 8'he2; 8'h99: r = 8'hf9; 8'h9a: r = 8'h37; 8'h9b: r = 8'he8; 8'h9c: r = 8'h1c; 8'h9d: r = 8'h75; 8'h9e: r = 8'hdf; 8'h9f: r = 8'h6e;
      8'ha0: r = 8'h47; 8'ha1: r = 8'hf1; 8'ha2: r = 8'h1a; 8'ha3: r = 8'h71; 8'ha4: r = 8'h1d; 8'ha5: r = 8'h29; 8'ha6: r = 8'hc5; 8'ha7: r = 8'h89; 8'ha8: r = 8'h6f; 8'ha9: r = 8'hb7; 8'haa: r = 8'h62; 8'hab: r = 8'h0e; 8'hac: r = 8'haa; 8'had: r = 8'h18; 8'hae: r = 8'hbe; 8'haf: r = 8'h1b;
      8'hb0: r = 8'hfc; 8'hb1: r = 8'h56; 8'hb2: r = 8'h3e; 8'hb3: r = 8'h4b; 8'hb4: r = 8'hc6; 8'hb5: r = 8'hd2; 8'hb6: r = 8'h79; 8'hb7: r = 8'h20; 8'hb8: r = 8'h9a; 8'hb9: r = 8'hdb; 8'hba: r = 8'hc0; 8'hbb: r = 8'hfe; 8'hbc: r = 8'h78; 8'hbd: r = 8'hcd; 8'hbe: r = 8'h5a; 8'hbf: r = 8'hf4;
      8'hc0: r = 8'h1f; 8'hc1: r = 8'hdd; 8'hc2: r = 8'ha8; 8'hc3: r = 8'h33; 8'hc4: r = 8'h88; 8'hc5: r = 8'h07; 8'hc6: r = 8'hc7; 8'hc7: r = 8'h31; 8'hc8: r = 8'hb1; 8'hc9: r = 8'h12; 8'hca: r = 8'h10; 8'hcb: r = 8'h59; 8'hcc: r = 8'h27; 8'hcd: r = 8'h80; 8'hce: r = 8'hec; 8'hcf: r = 8'h5f;
      8'hd0: r = 8'h60; 8'hd1: r = 8'h51; 8'hd2: r = 8'h7f; 8'hd3: r = 8'ha9; 8'hd4: r = 8'h19; 8'hd5: r = 8'hb5; 8'hd6: r = 8'h4a; 8'hd7: r = 8'h0d; 8'hd8: r = 8'h2d; 8'hd9: r = 8'he5; 8'hda: r = 8'h7a; 8'hdb: r = 8'h9f; 8'hdc: r = 8'h93; 8'hdd: r = 8'hc9; 8'hde: r = 8'h9c; 8'hdf: r = 8'hef;
      8'he0: r = 8'ha0; 8'he1: r = 8'he0; 8'he2: r = 8'h3b; 8'he3: r = 8'h4d; 8'he4: r = 8'hae; 8'he5: r = 8'h2a; 8'he6: r = 8'hf5; 8'he7: r = 8'hb0; 8'he8: r = 8'hc8; 8'he9: r = 8'heb; 8'hea: r = 8'hbb; 8'heb: r = 8'h3c; 8'hec: r = 8'h83; 8'hed: r = 8'h53; 8'hee: r = 8'h99; 8'hef: r = 8'h61;
      8'hf0: r = 8'h17; 8'hf1: r = 8'h2b; 8'hf2: r = 8'h04; 8'hf3: r = 8'h7e; 8'hf4: r = 8'hba; 8'hf5: r = 8'h77; 8'hf6: r = 8'hd6; 8'hf7: r = 8'h26; 8'hf8: r = 8'he1; 8'hf9: r = 8'h69; 8'hfa: r = 8'h14; 8'hfb: r = 8'h63; 8'hfc: r = 8'h55; 8'hfd: r = 8'h21; 8'hfe: r = 8'h0c; 8'hff: r = 8'h7d;
    endcase
    return r;
  endfunction
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [3:0] m);
    logic [7:0] x2, x4, x8;
    x2 = xtime(a);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return ({8{m[0]}} & a) ^ ({8{m[1]}} & x2) ^ ({8{m[2]}} & x4) ^ ({8{m[3]}} & x8);
  endfunction
  // cf holds the first matrix row as nibbles; later rows are its right rotations
  function automatic logic [127:0] mix(input logic [127:0] s, input logic [15:0] cf);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        for (int j = 0; j < 4; j++)
          o[127-8*(4*c+r) -: 8] = o[127-8*(4*c+r) -: 8] ^ gmul(s[127-8*(4*c+j) -: 8], cf[15-4*((j-r+4)%4) -: 4]);
    return o;
  endfunction
  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    return mix(s, 16'h2311);
  endfunction
  function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
    return mix(s, 16'hebd9);
  endfunction
  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[127-8*(4*((i/4+i%4)%4)+i%4) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = s[127-8*(4*((i/4-i%4+4)%4)+i%4) -: 8];
    return o;
  endfunction
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction
  function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    for (int i = 0; i < 16; i++) o[8*i +: 8] = inv_sbox(s[8*i +: 8]);
    return o;
  endfunction
  function automatic logic [127:0] key_next(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, w0, w1, w2, w3;
    t = {sbox(k[23:16]) ^ rc, sbox(k[15:8]), sbox(k[7:0]), sbox(k[31:24])};
    w0 = k[127:96] ^ t;
    w1 = k[95:64] ^ w0;
    w2 = k[63:32] ^ w1;
    w3 = k[31:0] ^ w2;
    return {w0, w1, w2, w3};
  endfunction
endpackage

// File: rtl/aes_round.sv
// aes_round: one combinational AES encrypt or decrypt round
module aes_round
  import aes_pkg::*;
#(
  parameter bit INV = 1'b0,
  parameter bit LAST = 1'b0
) (
  input  logic [127:0] state,
  input  logic [127:0] round_key,
  output logic [127:0] result
);
  logic [127:0] t;
  always_comb begin
    t = INV ? inv_sub_bytes(inv_shift_rows(state)) ^ round_key : shift_rows(sub_bytes(state));
    result = INV ? (LAST ? t : inv_mix_columns(t)) : (LAST ? t : mix_columns(t)) ^ round_key;
  end
endmodule

// File: rtl/aes_top.sv
// aes_top: AES-128 key expansion plus unrolled encrypt and decrypt pipelines
module aes_top #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         sys_en,
  input  logic         load_new_key,
  input  logic [127:0] cipher_key,
  input  logic         enc_in_valid,
  input  logic [127:0] plain_text,
  output logic         enc_out_valid,
  output logic [127:0] cipher_text_out,
  input  logic         dec_in_valid,
  input  logic [127:0] cipher_text_in,
  output logic         dec_out_valid,
  output logic [127:0] plain_text_out,
  output logic         done_key_expansion,
  output logic         key_is_valid
);
  import aes_pkg::*;
  logic [127:0] rk [0:NR];
  logic [127:0] cur_key;
  logic [3:0] kcnt;
  logic busy;
  logic [127:0] es [0:NR];
  logic [127:0] ds [0:NR];
  logic [127:0] er [1:NR];
  logic [127:0] dr [1:NR];
  logic [NR:0] ev, dv;
  logic [127:0] nk;
  assign nk = key_next(cur_key, RCON[kcnt]);
  genvar i;
  generate
    for (i = 1; i <= NR; i++) begin : g_round
      aes_round #(.INV(1'b0), .LAST(i == NR)) u_enc (.state(es[i-1]), .round_key(rk[i]), .result(er[i]));
      aes_round #(.INV(1'b1), .LAST(i == NR)) u_dec (.state(ds[i-1]), .round_key(rk[NR-i]), .result(dr[i]));
    end
  endgenerate
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kcnt <= '0;
      busy <= 1'b0;
      done_key_expansion <= 1'b0;
      key_is_valid <= 1'b0;
    end else if (sys_en) begin
      done_key_expansion <= 1'b0;
      if (load_new_key) begin
        rk[0] <= cipher_key;
        cur_key <= cipher_key;
        kcnt <= 4'd1;
        busy <= 1'b1;
        key_is_valid <= 1'b0;
      end else if (busy) begin
        rk[kcnt] <= nk;
        cur_key <= nk;
        kcnt <= kcnt + 4'd1;
        if (kcnt == 4'(NR)) begin
          busy <= 1'b0;
          done_key_expansion <= 1'b1;
          key_is_valid <= 1'b1;
        end
      end
    end
  end
  // a key load flushes every block in flight, including the one about to leave
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ev <= '0;
      dv <= '0;
      enc_out_valid <= 1'b0;
      dec_out_valid <= 1'b0;
      cipher_text_out <= '0;
      plain_text_out <= '0;
    end else if (sys_en) begin
      ev <= load_new_key ? '0 : {ev[NR-1:0], enc_in_valid & key_is_valid};
      dv <= load_new_key ? '0 : {dv[NR-1:0], dec_in_valid & key_is_valid};
      enc_out_valid <= ev[NR] & ~load_new_key;
      dec_out_valid <= dv[NR] & ~load_new_key;
      if (ev[NR] && !load_new_key) cipher_text_out <= es[NR];
      if (dv[NR] && !load_new_key) plain_text_out <= ds[NR];
      es[0] <= plain_text ^ rk[0];
      ds[0] <= cipher_text_in ^ rk[NR];
      for (int k = 1; k <= NR; k++) begin
        es[k] <= er[k];
        ds[k] <= dr[k];
      end
    end
  end
endmodule

// File: tb/tb_aes_top.sv
// tb_aes_top: scoreboard bench for aes_top using published AES-128 vectors
module tb_aes_top;
  typedef struct {
    logic [127:0] d;
    int c;
  } exp_t;
  logic clk = 1'b0, rst_n = 1'b0, sys_en = 1'b1, load_new_key = 1'b0;
  logic [127:0] cipher_key = '0, plain_text = '0, cipher_text_in = '0;
  logic enc_in_valid = 1'b0, dec_in_valid = 1'b0;
  logic enc_out_valid, dec_out_valid, done_key_expansion, key_is_valid;
  logic [127:0] cipher_text_out, plain_text_out;
  int compared = 0, mismatched = 0, ncyc = 0;
  logic edge_en = 1'b0;
  exp_t enc_q[$], dec_q[$];
  exp_t eit, dit;
  localparam logic [127:0] K1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] P1 = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] K2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  logic [127:0] p2 [0:3] = '{128'h6bc1bee22e409f96e93d7e117393172a, 128'hae2d8a571e03ac9c9eb76fac45af8e51,
                             128'h30c81c46a35ce411e5fbc1191a0a52ef, 128'hf69f2445df4f9b17ad2b417be66c3710};
  logic [127:0] c2 [0:3] = '{128'h3ad77bb40d7a3660a89ecaf32466ef97, 128'hf5d3d58503b9699de785895a96fdbaaf,
                             128'h43b1cd7f598ece23881b00e3ed030688, 128'h7b0c785e27e8ad3f8223207104725dd4};

  aes_top #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .sys_en(sys_en), .load_new_key(load_new_key), .cipher_key(cipher_key),
    .enc_in_valid(enc_in_valid), .plain_text(plain_text), .enc_out_valid(enc_out_valid),
    .cipher_text_out(cipher_text_out), .dec_in_valid(dec_in_valid), .cipher_text_in(cipher_text_in),
    .dec_out_valid(dec_out_valid), .plain_text_out(plain_text_out),
    .done_key_expansion(done_key_expansion), .key_is_valid(key_is_valid)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    edge_en <= sys_en & rst_n;
    if (sys_en && rst_n) ncyc <= ncyc + 1;
  end

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (edge_en && enc_out_valid) begin
      if (enc_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL enc_unexpected: got %h at cycle %0d expected no output", cipher_text_out, ncyc);
      end else begin
        eit = enc_q.pop_front();
        chk("enc_data", cipher_text_out, eit.d);
        chk("enc_latency", 128'(ncyc), 128'(eit.c));
      end
    end
    if (edge_en && dec_out_valid) begin
      if (dec_q.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL dec_unexpected: got %h at cycle %0d expected no output", plain_text_out, ncyc);
      end else begin
        dit = dec_q.pop_front();
        chk("dec_data", plain_text_out, dit.d);
        chk("dec_latency", 128'(ncyc), 128'(dit.c));
      end
    end
  end

  // accept happens at the coming edge (ncyc+1); output is seen eleven enabled edges later
  task automatic drive(input bit e, input bit d, input bit push, input logic [127:0] pt, input logic [127:0] ec,
                       input logic [127:0] ct, input logic [127:0] dc);
    enc_in_valid = e;
    plain_text = pt;
    dec_in_valid = d;
    cipher_text_in = ct;
    if (push && e) enc_q.push_back('{d: ec, c: ncyc + 12});
    if (push && d) dec_q.push_back('{d: dc, c: ncyc + 12});
    @(negedge clk);
  endtask

  task automatic idle();
    enc_in_valid = 1'b0;
    dec_in_valid = 1'b0;
  endtask

  task automatic load_key(input logic [127:0] k);
    cipher_key = k;
    load_new_key = 1'b1;
    @(negedge clk);
    load_new_key = 1'b0;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_key_expansion && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("key_done", 128'(done_key_expansion), 128'd1);
    chk("key_valid", 128'(key_is_valid), 128'd1);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_enc_valid"}, 128'(enc_out_valid), 128'd0);
    chk({tag, "_dec_valid"}, 128'(dec_out_valid), 128'd0);
    chk({tag, "_done"}, 128'(done_key_expansion), 128'd0);
    chk({tag, "_key_valid"}, 128'(key_is_valid), 128'd0);
    chk({tag, "_cipher_out"}, cipher_text_out, 128'd0);
    chk({tag, "_plain_out"}, plain_text_out, 128'd0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) drive(1'b1, 1'b1, 1'b0, P1, '0, C1, '0);
    idle();
    load_key(K1);
    for (int k = 1; k <= 11; k++) begin
      @(negedge clk);
      if (k >= 9) begin
        chk("expand_done_pulse", 128'(done_key_expansion), 128'(k == 10));
        chk("expand_key_valid", 128'(key_is_valid), 128'(k >= 10));
      end
    end
    drive(1'b1, 1'b1, 1'b1, P1, C1, C1, P1);
    idle();
    repeat (15) @(negedge clk);
    load_key(K2);
    wait_done();
    for (int k = 0; k < 4; k++) drive(1'b1, 1'b1, 1'b1, p2[k], c2[k], c2[3-k], p2[3-k]);
    idle();
    repeat (2) @(negedge clk);
    sys_en = 1'b0;
    repeat (10) @(negedge clk);
    sys_en = 1'b1;
    repeat (20) @(negedge clk);
    load_key(K2);
    repeat (4) @(negedge clk);
    load_key(K1);
    wait_done();
    drive(1'b1, 1'b0, 1'b1, P1, C1, '0, '0);
    idle();
    repeat (15) @(negedge clk);
    for (int k = 0; k < 2; k++) drive(1'b1, 1'b1, 1'b0, P1, '0, C1, '0);
    idle();
    repeat (3) @(negedge clk);
    load_key(K1);
    wait_done();
    repeat (15) @(negedge clk);
    for (int k = 0; k < 2; k++) drive(1'b1, 1'b1, 1'b0, P1, '0, C1, '0);
    idle();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk_zero("midreset");
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    chk("enc_queue_drained", 128'(enc_q.size()), 128'd0);
    chk("dec_queue_drained", 128'(dec_q.size()), 128'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
